// File: rtl/flex_fifo_pkg.sv
// Shared definitions for flex_fifo: read-mode constants and an
// elaboration-time sanity check on depth and threshold parameters.
package flex_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // True when both thresholds lie within 0..FIFO_DEPTH for the given pointer width.
    function automatic bit fifo_params_ok(input int addr_width,
                                          input int afull_th,
                                          input int aempty_th);
        int depth;
        depth = 2 ** addr_width;
        return (addr_width >= 1) &&
               (afull_th  >= 0) && (afull_th  <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth);
    endfunction

endpackage

// File: rtl/flex_fifo_mem.sv
// Simple dual-port storage for flex_fifo: one write port, one read port that is
// either registered (loaded on re) or combinational, chosen by REG_READ.
module flex_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter bit REG_READ   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Array contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= mem[raddr];
                end
            end

            assign rdata = rdata_q;
        end else begin : g_comb_read
            logic unused_ctrl;

            assign unused_ctrl = &{1'b0, rst_n, re};
            assign rdata       = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/flex_fifo.sv
// Synchronous FIFO with registered status flags, selectable registered-read or
// first-word-fall-through output, and one-cycle overflow/underflow pulses.
module flex_fifo
    import flex_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 12,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  is_empty,
    output logic                  is_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   data_avail,
    output logic [ADDR_WIDTH:0]   room_avail,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            FIFO_DEPTH = 2 ** ADDR_WIDTH;
    localparam int            CW         = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C   = CW'(AEMPTY_TH);

    generate
        if (!fifo_params_ok(ADDR_WIDTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_threshold
            $error("flex_fifo: AFULL_TH/AEMPTY_TH must lie in 0..FIFO_DEPTH");
        end
        if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
            $error("flex_fifo: FWFT must be FIFO_MODE_STD or FIFO_MODE_FWFT");
        end
    endgenerate

    // Requests are fire-and-forget: a write/read is accepted at the edge when
    // w_en/r_en is high and the registered full/empty flag permits it; there is
    // no back-pressure beyond the flags, and a refused request only pulses
    // overflow/underflow in the following cycle.
    logic          wr_ok;
    logic          rd_ok;
    logic [CW-1:0] w_ptr;
    logic [CW-1:0] r_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] room_q;
    logic          empty_q;
    logic          full_q;
    logic          aempty_q;
    logic          afull_q;
    logic          ovf_q;
    logic          unf_q;
    logic          rvalid_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign wr_ok = w_en & ~full_q;
    assign rd_ok = r_en & ~empty_q;

    // Reset folds into count_d so every flag register derives from one value.
    always_comb begin
        count_d = count_q;
        if (!rst_n) begin
            count_d = '0;
        end else if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            ovf_q    <= w_en & full_q;
            unf_q    <= r_en & empty_q;
            rvalid_q <= rd_ok;
        end
    end

    // Status registers track the post-update count with no extra cycle of lag.
    always_ff @(posedge clk) begin
        count_q  <= count_d;
        room_q   <= DEPTH_C - count_d;
        empty_q  <= (count_d == '0);
        full_q   <= (count_d == DEPTH_C);
        aempty_q <= (count_d <= AEMPTY_C);
        afull_q  <= (count_d >= AFULL_C);
    end

    flex_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (FWFT == FIFO_MODE_STD)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (w_ptr[ADDR_WIDTH-1:0]),
        .wdata (w_data),
        .re    (rd_ok),
        .raddr (r_ptr[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    assign r_data       = mem_rdata;
    assign r_valid      = (FWFT == FIFO_MODE_FWFT) ? ~empty_q : rvalid_q;
    assign is_empty     = empty_q;
    assign is_full      = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign data_avail   = count_q;
    assign room_avail   = room_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
